ad_bus_initiator: RTL and testbench
===================================

Name: ad_bus_initiator

Overview:
- Bus initiator for the pine16 multiplexed address/data bus.
- Accepts single read/write requests from the CPU core.
- Sequences the external bus as A[15:8] plus multiplexed AD[7:0]. The address byte on AD is latched off-bus by a '573-type transparent latch strobed by ALE.
- Generates ALE, RD_n and WR_n, inserts wait states on READY, and returns read data to the core.

Parameters:
- TIMEOUT, default 255: max T3 wait cycles before abort. Used only with BUS_TIMEOUT_EN; legal range 1..255.
- CNT_W, default 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  initiator can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  16  byte address.
- req_wdata  in  8  write data.
- resp_valid  out  1  one-cycle pulse: transaction complete.
- resp_rdata  out  8  read data; valid with resp_valid on reads, 0 on writes.
- resp_err  out  1  timeout abort flag; valid with resp_valid.
- a_hi  out  8  address bits 15:8, non-multiplexed.
- ad_out  out  8  AD bus drive value.
- ad_oe  out  1  AD output enable; the top-level tristate uses it.
- ad_in  in  8  AD bus sampled value.
- ale  out  1  address latch enable, active high.
- rd_n  out  1  read strobe, active low.
- wr_n  out  1  write strobe, active low.
- ready  in  1  target ready; synchronous to clk.

Behaviour:
- All bus outputs are registered. Requests are latched on acceptance, so later changes on req_* do not affect an in-flight transaction.
- Reset values: state = IDLE, ale = 0, rd_n = 1, wr_n = 1, ad_oe = 0, ad_out = 0, a_hi = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0. req_ready = 1 once rst deasserts.
- Reset is asynchronous. Asserting rst mid-transaction forces the strobes inactive immediately and aborts silently; no resp_valid is issued.
- State encoding: IDLE, T1, T2, T3, T4.
- Accept: a request is taken on the edge where req_valid && req_ready. req_ready = 1 in IDLE and in T4, 0 otherwise.
- IDLE:
  - All strobes inactive, ad_oe = 0.
  - On accept, go to T1.
- T1:
  - ale = 1, ad_oe = 1, ad_out = addr[7:0], a_hi = addr[15:8].
  - Always go to T2.
- T2:
  - ale = 0 (falling edge latches the address). ad_out still holds the address for latch hold time; ad_oe = 1.
  - Always go to T3.
- T3, write: ad_out = wdata, ad_oe = 1, wr_n = 0.
- T3, read: ad_oe = 0, rd_n = 0.
- T3 exit: stay in T3 while ready = 0. On the edge where ready = 1:
  - capture ad_in into resp_rdata (reads only);
  - go to T4.
- T4:
  - rd_n = wr_n = 1.
  - Write: ad_oe stays 1 with wdata held (data hold).
  - Read: ad_oe = 0.
  - resp_valid = 1 for exactly this cycle.
  - If a request is accepted in T4, go to T1; otherwise go to IDLE.
- a_hi holds its value from T1 through T4.
- Timing:
  - Zero-wait transaction: 4 cycles from T1 to T4 inclusive.
  - Back-to-back throughput: one transaction per 4 cycles plus wait states.
- No AD contention: ad_oe is never 1 while rd_n = 0.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - The wait counter clears on T3 entry and increments each T3 cycle with ready = 0.
  - When the count reaches TIMEOUT while ready is still 0, the FSM goes to T4 with resp_err = 1 and resp_rdata = 0.
  - If ready = 1 and the count reaches TIMEOUT in the same cycle, ready wins: normal completion, resp_err = 0.
- Undefined: T3 waits indefinitely; resp_err is tied to 0; counter logic is absent.

Decomposition:
- Package pine16_bus_pkg holds:
  - state encoding constants (IDLE, T1, T2, T3, T4);
  - AD_W = 8 and ADDR_W = 16;
  - strobe inactive-level constants.
- One natural sub-module: ad_bus_wait_timer (CNT_W-bit counter with clear/enable/expire), instantiated only under BUS_TIMEOUT_EN.

Test Plan:
- Reset release:
  - Stimulus: deassert rst, hold req_valid = 0.
  - Required response: rd_n = wr_n = 1, ale = 0, ad_oe = 0, req_ready = 1.
- Zero-wait write:
  - Stimulus: addr = 0x12A5, wdata = 0x3C, ready = 1.
  - Required response, by cycle:
    - T1: ale = 1, ad_out = 0xA5, a_hi = 0x12.
    - T2: ale = 0, ad_out = 0xA5.
    - T3: wr_n = 0, ad_out = 0x3C.
    - T4: resp_valid = 1, resp_err = 0.
  - 4 cycles total.
- Read with waits:
  - Stimulus: addr = 0x00FF, ready low for 3 T3 cycles, ad_in = 0x5A when ready rises.
  - Required response: rd_n low for 4 cycles, ad_oe = 0 throughout T3, resp_rdata = 0x5A with resp_valid.
- Back-to-back:
  - Stimulus: write 0x1000 then read 0x1001, req_valid held high.
  - Required response: second T1 immediately follows the first T4; no IDLE cycle.
- Reset mid-T3 read:
  - Stimulus: assert rst during T3.
  - Required response: rd_n = 1 immediately (asynchronous), no resp_valid; next request behaves normally.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT = 4):
  - Stimulus: ready held 0.
  - Required response: T4 after 4 wait cycles, resp_err = 1, resp_rdata = 0.

Source files
------------

// File: rtl/pine16_bus_pkg.sv
// pine16_bus_pkg: shared definitions for the pine16 multiplexed AD bus.
//   - Bus cycle state encoding (IDLE, T1..T4)
//   - Bus widths (AD_W, ADDR_W)
//   - Inactive/active levels for ALE and the active-low strobes
package pine16_bus_pkg;

    localparam int AD_W   = 8;
    localparam int ADDR_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4
    } bus_state_t;

    localparam logic STROBE_OFF = 1'b1;
    localparam logic STROBE_ON  = 1'b0;
    localparam logic ALE_OFF    = 1'b0;
    localparam logic ALE_ON     = 1'b1;

endpackage

// File: rtl/ad_bus_wait_timer.sv
// ad_bus_wait_timer: wait-state counter used to abort a stalled T3.
// Only instantiated when BUS_TIMEOUT_EN is defined.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   i_clr    in   hold counter at zero
//   i_en     in   count one wait cycle
//   o_expire out  high in the wait cycle that completes TIMEOUT waits
module ad_bus_wait_timer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    // Expire is flagged while the last wait cycle is in progress so the FSM
    // leaves T3 on the edge that ends the TIMEOUT-th wait cycle.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_en && (r_cnt == LAST_CNT);

endmodule

// File: rtl/ad_bus_initiator.sv
// ad_bus_initiator: single-transfer bus initiator for the pine16 multiplexed
// address/data bus (A[15:8] plus AD[7:0], address byte latched by ALE).
//
// Optional feature macro: BUS_TIMEOUT_EN
//   defined   -> T3 aborts after TIMEOUT wait cycles with resp_err = 1
//   undefined -> T3 waits for ready indefinitely, resp_err tied to 0
//
// Ports:
//   clk, rst              system clock, async active-high reset
//   req_valid/req_ready   core request handshake
//   req_we/addr/wdata     request payload (latched on acceptance)
//   resp_valid            one-cycle completion pulse
//   resp_rdata/resp_err   read data / timeout flag, valid with resp_valid
//   a_hi                  non-multiplexed address bits 15:8
//   ad_out/ad_oe/ad_in    AD bus drive value, output enable, sampled value
//   ale, rd_n, wr_n       bus strobes
//   ready                 target ready (synchronous)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | bus quiet, waiting for a request
// T1    | address phase: ALE high, address byte driven on AD
// T2    | ALE low latches address; AD still holds it for latch hold time
// T3    | data phase: strobe active, wait here while ready is low
// T4    | strobes released, write data held, resp_valid pulse
module ad_bus_initiator
    import pine16_bus_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [AD_W-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [AD_W-1:0]   resp_rdata,
    output logic              resp_err,
    output logic [7:0]        a_hi,
    output logic [AD_W-1:0]   ad_out,
    output logic              ad_oe,
    input  logic [AD_W-1:0]   ad_in,
    output logic              ale,
    output logic              rd_n,
    output logic              wr_n,
    input  logic              ready
);

    if (TIMEOUT < 1 || TIMEOUT > 255 || (1 << CNT_W) <= TIMEOUT) begin : g_param_check
        $error("ad_bus_initiator: TIMEOUT must be 1..255 and fit in CNT_W bits");
    end

    bus_state_t r_state;
    bus_state_t w_state_nxt;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [AD_W-1:0]   r_wdata;

    logic              r_ale, r_rd_n, r_wr_n, r_ad_oe, r_resp_valid;
    logic [AD_W-1:0]   r_ad_out, r_resp_rdata;
    logic [7:0]        r_a_hi;

    logic              w_accept;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [AD_W-1:0]   w_wdata_nxt;
    logic              w_timeout;
    logic              w_ale_nxt, w_rd_n_nxt, w_wr_n_nxt, w_ad_oe_nxt;
    logic [AD_W-1:0]   w_ad_out_nxt, w_rdata_nxt;
    logic [7:0]        w_a_hi_nxt;
    logic              w_t3_exit;

    assign req_ready = (r_state == IDLE) || (r_state == T4);
    assign w_accept  = req_valid && req_ready;

    // Outputs are registered from the next state, so the payload seen on the
    // accepting edge must come straight from the request port.
    assign w_we_nxt    = w_accept ? req_we    : r_we;
    assign w_addr_nxt  = w_accept ? req_addr  : r_addr;
    assign w_wdata_nxt = w_accept ? req_wdata : r_wdata;

    assign w_t3_exit = (r_state == T3) && (w_state_nxt == T4);

`ifdef BUS_TIMEOUT_EN
    logic r_resp_err;
    logic w_err_nxt;

    ad_bus_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (r_state != T3),
        .i_en     ((r_state == T3) && !ready),
        .o_expire (w_timeout)
    );

    // ready has priority: a timeout only counts when ready is still low.
    always_comb begin
        w_err_nxt = r_resp_err;
        if (w_t3_exit) begin
            w_err_nxt = !ready;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_err <= 1'b0;
        end else begin
            r_resp_err <= w_err_nxt;
        end
    end

    assign resp_err = r_resp_err;
`else
    assign w_timeout = 1'b0;
    assign resp_err  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = T1;
            T1:   w_state_nxt = T2;
            T2:   w_state_nxt = T3;
            T3:   if (ready || w_timeout) w_state_nxt = T4;
            T4:   w_state_nxt = w_accept ? T1 : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_ale_nxt    = ALE_OFF;
        w_rd_n_nxt   = STROBE_OFF;
        w_wr_n_nxt   = STROBE_OFF;
        w_ad_oe_nxt  = 1'b0;
        w_ad_out_nxt = '0;
        w_a_hi_nxt   = r_a_hi;
        case (w_state_nxt)
            T1: begin
                w_ale_nxt    = ALE_ON;
                w_ad_oe_nxt  = 1'b1;
                w_ad_out_nxt = w_addr_nxt[7:0];
                w_a_hi_nxt   = w_addr_nxt[15:8];
            end
            T2: begin
                w_ad_oe_nxt  = 1'b1;
                w_ad_out_nxt = w_addr_nxt[7:0];
            end
            T3: begin
                if (w_we_nxt) begin
                    w_ad_oe_nxt  = 1'b1;
                    w_ad_out_nxt = w_wdata_nxt;
                    w_wr_n_nxt   = STROBE_ON;
                end else begin
                    w_rd_n_nxt   = STROBE_ON;
                end
            end
            T4: begin
                if (w_we_nxt) begin
                    w_ad_oe_nxt  = 1'b1;
                    w_ad_out_nxt = w_wdata_nxt;
                end
            end
            default: ;
        endcase
    end

    // Read data is captured only when ready completes the read; writes and
    // timeouts report zero.
    always_comb begin
        w_rdata_nxt = r_resp_rdata;
        if (w_t3_exit) begin
            w_rdata_nxt = (ready && !r_we) ? ad_in : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_ale        <= ALE_OFF;
            r_rd_n       <= STROBE_OFF;
            r_wr_n       <= STROBE_OFF;
            r_ad_oe      <= 1'b0;
            r_ad_out     <= '0;
            r_a_hi       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_we         <= w_we_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_ale        <= w_ale_nxt;
            r_rd_n       <= w_rd_n_nxt;
            r_wr_n       <= w_wr_n_nxt;
            r_ad_oe      <= w_ad_oe_nxt;
            r_ad_out     <= w_ad_out_nxt;
            r_a_hi       <= w_a_hi_nxt;
            r_resp_valid <= (w_state_nxt == T4);
            r_resp_rdata <= w_rdata_nxt;
        end
    end

    assign ale        = r_ale;
    assign rd_n       = r_rd_n;
    assign wr_n       = r_wr_n;
    assign ad_oe      = r_ad_oe;
    assign ad_out     = r_ad_out;
    assign a_hi       = r_a_hi;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_ad_bus_initiator.sv
// tb_ad_bus_initiator: directed bench for ad_bus_initiator. Expected
// responses are queued when a request is driven and compared by a monitor
// when resp_valid pulses; bus pins are checked cycle by cycle in the main flow.
`define CHK(tag, obs, exp) chk(tag, 16'(obs), 16'(exp))

module tb_ad_bus_initiator;

`ifdef BUS_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        resp_valid, resp_err;
    logic [7:0]  resp_rdata, a_hi, ad_out, ad_in;
    logic        ad_oe, ale, rd_n, wr_n, ready;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } resp_t;

    resp_t sb_q[$];
    resp_t mon_e;
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_resp   = 0;
    int    rd_low;
    int    resp_snap;
    bit    seen;

    ad_bus_initiator #(
        .TIMEOUT (TB_TIMEOUT),
        .CNT_W   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .a_hi       (a_hi),
        .ad_out     (ad_out),
        .ad_oe      (ad_oe),
        .ad_in      (ad_in),
        .ale        (ale),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic we, input logic [15:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic wait_resp(input string tag, input int max_cyc);
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        `CHK(tag, seen, 1);
    endtask

    // Response scoreboard and AD contention monitor.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_checks++;
            if ((ad_oe === 1'b1) && (rd_n === 1'b0))
                $error("FAIL no_contention: ad_oe=1 while rd_n=0");
            else
                n_pass++;
            if (resp_valid === 1'b1) begin
                n_resp++;
                n_checks++;
                if (sb_q.size() != 0) begin
                    n_pass++;
                    mon_e = sb_q.pop_front();
                    n_checks++;
                    if (resp_rdata === mon_e.rdata) n_pass++;
                    else $error("FAIL resp_rdata: observed %h, expected %h", resp_rdata, mon_e.rdata);
                    n_checks++;
                    if (resp_err === mon_e.err) n_pass++;
                    else $error("FAIL resp_err: observed %b, expected %b", resp_err, mon_e.err);
                end else begin
                    $error("FAIL resp_expected: unexpected resp_valid");
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        ad_in = '0; ready = 1'b1;
        repeat (2) @(negedge clk);
        `CHK("rst_ale", ale, 0);
        `CHK("rst_rd_n", rd_n, 1);
        `CHK("rst_wr_n", wr_n, 1);
        `CHK("rst_ad_oe", ad_oe, 0);
        `CHK("rst_ad_out", ad_out, 8'h00);
        `CHK("rst_a_hi", a_hi, 8'h00);
        `CHK("rst_resp_valid", resp_valid, 0);
        `CHK("rst_resp_rdata", resp_rdata, 8'h00);
        `CHK("rst_resp_err", resp_err, 0);
        rst = 1'b0;
        @(negedge clk);
        `CHK("rel_req_ready", req_ready, 1);
        `CHK("rel_rd_n", rd_n, 1);
        `CHK("rel_wr_n", wr_n, 1);
        `CHK("rel_ale", ale, 0);
        `CHK("rel_ad_oe", ad_oe, 0);

        // Zero-wait write
        drive(1'b1, 16'h12A5, 8'h3C);
        sb_q.push_back('{rdata: 8'h00, err: 1'b0});
        @(negedge clk);
        `CHK("w_t1_ale", ale, 1);
        `CHK("w_t1_ad_out", ad_out, 8'hA5);
        `CHK("w_t1_a_hi", a_hi, 8'h12);
        `CHK("w_t1_ad_oe", ad_oe, 1);
        `CHK("w_t1_req_ready", req_ready, 0);
        req_valid = 1'b0; req_addr = 16'hFFFF; req_wdata = 8'hEE; req_we = 1'b0;
        @(negedge clk);
        `CHK("w_t2_ale", ale, 0);
        `CHK("w_t2_ad_out", ad_out, 8'hA5);
        `CHK("w_t2_ad_oe", ad_oe, 1);
        `CHK("w_t2_wr_n", wr_n, 1);
        @(negedge clk);
        `CHK("w_t3_wr_n", wr_n, 0);
        `CHK("w_t3_ad_out", ad_out, 8'h3C);
        `CHK("w_t3_ad_oe", ad_oe, 1);
        `CHK("w_t3_rd_n", rd_n, 1);
        `CHK("w_t3_a_hi", a_hi, 8'h12);
        @(negedge clk);
        `CHK("w_t4_resp_valid", resp_valid, 1);
        `CHK("w_t4_wr_n", wr_n, 1);
        `CHK("w_t4_ad_oe", ad_oe, 1);
        `CHK("w_t4_ad_out", ad_out, 8'h3C);
        `CHK("w_t4_req_ready", req_ready, 1);
        @(negedge clk);
        `CHK("w_idle_resp_valid", resp_valid, 0);
        `CHK("w_idle_ad_oe", ad_oe, 0);
        `CHK("w_idle_a_hi", a_hi, 8'h12);

        // Read with three wait states
        ready = 1'b0; ad_in = 8'h00;
        drive(1'b0, 16'h00FF, 8'h00);
        sb_q.push_back('{rdata: 8'h5A, err: 1'b0});
        @(negedge clk);
        `CHK("r_t1_ale", ale, 1);
        `CHK("r_t1_ad_out", ad_out, 8'hFF);
        `CHK("r_t1_a_hi", a_hi, 8'h00);
        req_valid = 1'b0;
        @(negedge clk);
        `CHK("r_t2_rd_n", rd_n, 1);
        `CHK("r_t2_ad_oe", ad_oe, 1);
        rd_low = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (rd_n === 1'b0) rd_low++;
            `CHK("r_t3_ad_oe", ad_oe, 0);
            if (i == 4) begin
                ready = 1'b1;
                ad_in = 8'h5A;
            end
        end
        @(negedge clk);
        ad_in = 8'h11;
        `CHK("r_rd_low_cycles", rd_low, 4);
        `CHK("r_t4_rd_n", rd_n, 1);
        `CHK("r_t4_resp_valid", resp_valid, 1);
        @(negedge clk);

        // Back-to-back write then read with req_valid held high
        ad_in = 8'hC3;
        drive(1'b1, 16'h1000, 8'h77);
        sb_q.push_back('{rdata: 8'h00, err: 1'b0});
        @(negedge clk);
        `CHK("bb_t1a_ale", ale, 1);
        `CHK("bb_t1a_a_hi", a_hi, 8'h10);
        `CHK("bb_t1a_ad_out", ad_out, 8'h00);
        drive(1'b0, 16'h1001, 8'h00);
        sb_q.push_back('{rdata: 8'hC3, err: 1'b0});
        @(negedge clk);
        @(negedge clk);
        `CHK("bb_t3a_wr_n", wr_n, 0);
        `CHK("bb_t3a_ad_out", ad_out, 8'h77);
        @(negedge clk);
        `CHK("bb_t4a_resp_valid", resp_valid, 1);
        `CHK("bb_t4a_req_ready", req_ready, 1);
        @(negedge clk);
        `CHK("bb_t1b_ale", ale, 1);
        `CHK("bb_t1b_ad_out", ad_out, 8'h01);
        `CHK("bb_t1b_a_hi", a_hi, 8'h10);
        `CHK("bb_t1b_resp_valid", resp_valid, 0);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        `CHK("bb_t3b_rd_n", rd_n, 0);
        `CHK("bb_t3b_ad_oe", ad_oe, 0);
        @(negedge clk);
        `CHK("bb_t4b_resp_valid", resp_valid, 1);
        @(negedge clk);
        `CHK("bb_idle_ale", ale, 0);
        `CHK("bb_idle_resp_valid", resp_valid, 0);

        // Asynchronous reset in the middle of a read T3
        ready = 1'b0;
        drive(1'b0, 16'h2233, 8'h00);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        `CHK("mr_t3_rd_n", rd_n, 0);
        resp_snap = n_resp;
        #2 rst = 1'b1;
        #1;
        `CHK("mr_async_rd_n", rd_n, 1);
        `CHK("mr_async_ad_oe", ad_oe, 0);
        `CHK("mr_async_ale", ale, 0);
        @(negedge clk);
        rst = 1'b0;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        `CHK("mr_no_resp", n_resp, resp_snap);
        `CHK("mr_req_ready", req_ready, 1);
        ad_in = 8'hA7;
        drive(1'b0, 16'h3344, 8'h00);
        sb_q.push_back('{rdata: 8'hA7, err: 1'b0});
        @(negedge clk);
        `CHK("mr_next_ale", ale, 1);
        `CHK("mr_next_a_hi", a_hi, 8'h33);
        `CHK("mr_next_ad_out", ad_out, 8'h44);
        req_valid = 1'b0;
        wait_resp("mr_next_resp", 8);
        @(negedge clk);

`ifdef BUS_TIMEOUT_EN
        // Timeout abort: ready never rises
        ready = 1'b0; ad_in = 8'h99;
        drive(1'b0, 16'h4455, 8'h00);
        sb_q.push_back('{rdata: 8'h00, err: 1'b1});
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rd_low = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (rd_n === 1'b0) rd_low++;
        end
        `CHK("to_resp_seen", seen, 1);
        `CHK("to_wait_cycles", rd_low, TB_TIMEOUT);
        @(negedge clk);

        // ready rising in the last allowed wait cycle completes normally
        drive(1'b0, 16'h5566, 8'h00);
        sb_q.push_back('{rdata: 8'h99, err: 1'b0});
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= TB_TIMEOUT; i++) begin
            @(negedge clk);
            if (i == TB_TIMEOUT) ready = 1'b1;
        end
        @(negedge clk);
        `CHK("to_ready_wins_resp", resp_valid, 1);
        @(negedge clk);
`endif

        @(negedge clk);
        `CHK("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        if (n_pass == n_checks) $display("PASS");
        else $error("FAIL: %0d checks failed", n_checks - n_pass);
        $finish;
    end

endmodule
